// File: rtl/counter_pkg.sv
// Shared types and helpers for the loadable modulo down counter.
package counter_pkg;

    // RUN: counting or idle; STOPPED: parked at zero after a one-shot expiry.
    typedef enum logic {
        RUN     = 1'b0,
        STOPPED = 1'b1
    } counter_state_t;

    // Saturate an out-of-range load to the top of the count range so the
    // counter can never be placed outside 0..modulus-1.
    function automatic int unsigned clamp_load(input int unsigned value,
                                               input int unsigned modulus);
        return (value < modulus) ? value : (modulus - 1);
    endfunction

endpackage

// File: rtl/modulo_12_down_counter.sv
// Loadable modulo-MODULUS down counter with continuous (wrap + borrow) and
// one-shot (stop at zero + done) modes. All outputs come straight from flops.
module modulo_12_down_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 12,   // count range 0..MODULUS-1, MODULUS >= 2
    parameter int WIDTH   = 4     // 2**WIDTH >= MODULUS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             one_shot,
    output logic [WIDTH-1:0] res,
    output logic             borrow,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    counter_state_t   state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = WIDTH'(clamp_load(32'(load_value), MODULUS));

    // Next-state: load beats enable; STOPPED ignores enable until a load.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        borrow_d = 1'b0;
        done_d   = done_q;
        if (load) begin
            res_d   = load_clamped;
            done_d  = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN && enable) begin
            if (res_q != '0) begin
                res_d = res_q - WIDTH'(1);
            end else if (one_shot) begin
                // Expire in place: zero stays on res, no wrap, no borrow.
                done_d  = 1'b1;
                state_d = STOPPED;
            end else begin
                res_d    = MAX_VAL;
                borrow_d = 1'b1;
            end
        end
    end

    // State and output registers; reset overrides everything on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RUN;
            res_q    <= MAX_VAL;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign res    = res_q;
    assign borrow = borrow_q;
    assign done   = done_q;

endmodule

// File: tb/tb_modulo_12_down_counter.sv
// Scoreboard bench: a default (mod 12) and a mod 10 instance share stimulus;
// a behavioural model pushes expected outputs per step, popped after the edge.
module tb_modulo_12_down_counter;

    typedef struct packed {
        logic [3:0] res;
        logic       borrow;
        logic       done;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic       one_shot = 1'b0;

    logic [3:0] res12, res10;
    logic       borrow12, borrow10, done12, done10;

    exp_t q12[$];
    exp_t q10[$];
    exp_t m12 = '0;
    exp_t m10 = '0;
    logic st12 = 1'b0;
    logic st10 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    modulo_12_down_counter u_dut12 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .load_value(load_value), .one_shot(one_shot),
        .res(res12), .borrow(borrow12), .done(done12)
    );

    modulo_12_down_counter #(.MODULUS(10), .WIDTH(4)) u_dut10 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .load_value(load_value), .one_shot(one_shot),
        .res(res10), .borrow(borrow10), .done(done10)
    );

    // Reference behaviour of one edge for a counter of modulus modn.
    task automatic model(input int modn, inout exp_t s, inout logic stopped);
        if (reset) begin
            s.res = 4'(modn - 1); s.borrow = 1'b0; s.done = 1'b0; stopped = 1'b0;
        end else if (load) begin
            s.res = (int'(load_value) < modn) ? load_value : 4'(modn - 1);
            s.borrow = 1'b0; s.done = 1'b0; stopped = 1'b0;
        end else if (!stopped && enable) begin
            s.borrow = 1'b0;
            if (s.res != 4'd0) s.res = s.res - 4'd1;
            else if (one_shot) begin s.done = 1'b1; stopped = 1'b1; end
            else begin s.res = 4'(modn - 1); s.borrow = 1'b1; end
        end else begin
            s.borrow = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, predict, clock, then pop and compare.
    task automatic step(input logic r, input logic ld, input logic en,
                        input logic os, input logic [3:0] lv, input string tag);
        exp_t e, o;
        reset = r; load = ld; enable = en; one_shot = os; load_value = lv;
        model(12, m12, st12); q12.push_back(m12);
        model(10, m10, st10); q10.push_back(m10);
        @(posedge clock);
        #1;
        e = q12.pop_front();
        o = '{res: res12, borrow: borrow12, done: done12};
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s mod12: observed res=%0d borrow=%0b done=%0b, expected res=%0d borrow=%0b done=%0b",
                   tag, o.res, o.borrow, o.done, e.res, e.borrow, e.done);
        end
        e = q10.pop_front();
        o = '{res: res10, borrow: borrow10, done: done10};
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s mod10: observed res=%0d borrow=%0b done=%0b, expected res=%0d borrow=%0b done=%0b",
                   tag, o.res, o.borrow, o.done, e.res, e.borrow, e.done);
        end
    endtask

    initial begin
        #1;
        // Reset held two cycles, then free run across several wraps.
        step(1, 0, 0, 0, 4'd0, "reset");
        step(1, 0, 1, 0, 4'd0, "reset_en");
        for (int i = 0; i < 26; i++) step(0, 0, 1, 0, 4'd0, "free_run");

        // Enable gating from 5: 4,4,4,3.
        step(0, 1, 0, 0, 4'd5, "load5");
        step(0, 0, 1, 0, 4'd0, "gate1");
        step(0, 0, 0, 0, 4'd0, "gate0a");
        step(0, 0, 0, 0, 4'd0, "gate0b");
        step(0, 0, 1, 0, 4'd0, "gate1b");

        // One-shot from 3: reaches zero, stops, ignores enable and one_shot clear.
        step(0, 1, 0, 1, 4'd3, "os_load3");
        for (int i = 0; i < 14; i++) step(0, 0, 1, 1, 4'd0, "os_run");
        for (int i = 0; i < 3; i++)  step(0, 0, 1, 0, 4'd0, "os_clear");

        // Load beats enable, clears done; clamp of 14.
        step(0, 1, 1, 0, 4'd7, "load_pri");
        step(0, 0, 1, 0, 4'd0, "resume");
        step(0, 1, 0, 0, 4'd14, "clamp14");
        step(0, 1, 0, 0, 4'd12, "clamp12");
        step(0, 0, 1, 0, 4'd0, "after_clamp");

        // Reset at zero together with enable: no wrap pulse.
        step(0, 1, 0, 0, 4'd0, "load0");
        step(1, 0, 1, 0, 4'd0, "rst_at0");
        // Reset while STOPPED, and reset coinciding with load.
        step(0, 1, 0, 1, 4'd0, "os_load0");
        step(0, 0, 1, 1, 4'd0, "os_stop0");
        step(0, 0, 1, 1, 4'd0, "os_hold0");
        step(1, 0, 1, 1, 4'd0, "rst_stopped");
        step(1, 1, 1, 0, 4'd3, "rst_vs_load");

        // Wrap on both moduli from a zero load, continuous mode.
        step(0, 1, 0, 0, 4'd0, "wrap_load0");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'd0, "wrap");

        // Random mix, reset kept rare.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/modulo_12_down_counter.md
Name: modulo_12_down_counter

Overview:
- Loadable modulo-N down counter, default modulus 12. It is the count-down counterpart of the existing modulo-12 up counter and is used for countdown timers and the borrow side of cascaded digit chains.
- Supports two modes:
  - Continuous: wraps 0 -> MODULUS-1 and pulses borrow.
  - One-shot: stops at 0 and flags done.
- All outputs are registered.

Parameters:
- MODULUS, 12, count range is 0..MODULUS-1; must be >= 2.
- WIDTH, 4, counter width; must satisfy 2**WIDTH >= MODULUS.

Ports:
- clock  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  decrement request, sampled each rising edge.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value loaded when load=1.
- one_shot  input  1  0 = continuous wrap; 1 = stop at zero. Sampled every cycle.
- res  output  WIDTH  current count.
- borrow  output  1  one-cycle pulse on the 0 -> MODULUS-1 wrap.
- done  output  1  level; high while stopped at zero in one-shot mode.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clock. Reset values:
  - res = MODULUS-1 (11)
  - borrow = 0
  - done = 0
  - state = RUN
- Per-edge priority: reset > load > enable > hold.
- FSM states: RUN, STOPPED.
- RUN, enable=1, res>0:
  - res <= res-1, borrow <= 0.
- RUN, enable=1, res==0, one_shot=0:
  - res <= MODULUS-1, borrow <= 1 for exactly one cycle (registered, coincident with res showing MODULUS-1).
- RUN, enable=1, res==0, one_shot=1:
  - res stays 0, borrow <= 0, done <= 1, state -> STOPPED.
- RUN, enable=0:
  - res holds, borrow <= 0.
- STOPPED:
  - res holds 0, done stays 1, enable is ignored, borrow stays 0.
  - Exits only on load or reset.
  - Clearing one_shot while STOPPED does not restart counting.
- Load (either state):
  - res <= load_value if load_value < MODULUS, else res <= MODULUS-1 (clamp).
  - done <= 0, borrow <= 0, state -> RUN.
  - Load has priority over enable in the same cycle: no decrement that cycle.
- Load of 0 in one-shot mode:
  - Next enabled edge moves to STOPPED (done=1). No borrow.
- Latency:
  - Every change is visible on the outputs one edge after the sampled inputs.
  - No combinational path from inputs to outputs.
- Reset mid-operation, including while STOPPED or coinciding with load or enable: reset wins and all outputs take their reset values.
- res never leaves the range 0..MODULUS-1 under any input sequence.

Decomposition:
- Shared package counter_pkg holds:
  - state enum counter_state_t {RUN, STOPPED}
  - helper function clamp_load(value, modulus)
- Default MODULUS and WIDTH stay as module parameters.
- No sub-module: a single always block for the FSM and counter plus registered outputs is sufficient.

Test Plan:
- Reset then free run: reset=1 for 2 cycles, then enable=1, one_shot=0.
  - res sequence 11,10,...,0,11,...
  - borrow=1 only in the cycle res=11 after the 0, i.e. every 12th enabled cycle.
  - done stays 0.
- Enable gating: toggle enable 1,0,0,1 starting from res=5 -> res = 4,4,4,3. borrow stays 0.
- One-shot stop: load 3 with one_shot=1, then enable=1 continuously.
  - res = 3,2,1,0, then done=1 and res holds 0 for 10 more cycles.
  - borrow never asserts.
  - Clearing one_shot leaves done=1.
- Load priority and clamp:
  - load=1, enable=1, load_value=7 -> res=7 the next cycle (no decrement).
  - load_value=14 -> res=11.
  - A load while STOPPED clears done and counting resumes.
- Mid-operation reset:
  - At res=0 in continuous mode, assert reset together with enable -> res=11, borrow=0 (no wrap pulse).
  - Reset while STOPPED -> done=0, state RUN.
- Parameter sweep: MODULUS=10, WIDTH=4.
  - Wrap from 0 to 9 with a single borrow pulse.
  - load_value=12 clamps to 9.
